// File: rtl/frequency_divider_if.sv
// rtl/frequency_divider_if.sv - command and divided-output bundle for frequency_divider
interface frequency_divider_if #(
    parameter int CNT_W = 2
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] count;
    logic             running;
    logic             clk_div2;
    logic             clk_out;
    logic             tick;
    logic             clk_div3;

    modport master (
        output start,
        output stop,
        input  count,
        input  running,
        input  clk_div2,
        input  clk_out,
        input  tick,
        input  clk_div3
    );

    modport slave (
        input  start,
        input  stop,
        output count,
        output running,
        output clk_div2,
        output clk_out,
        output tick,
        output clk_div3
    );
endinterface

// File: rtl/frequency_divider.sv
// rtl/frequency_divider.sv - start/stop-controlled binary divider with wrap tick
// Optional FREQDIV_DIV3_EN adds a 50%-duty clk/3 output built from a negedge-retimed mod-3 counter.
module frequency_divider #(
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    frequency_divider_if.slave bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tick_q;
    logic             tick_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state   <= state_next;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    // start overrides stop, stop overrides counting
    always_comb begin
        state_next = state;
        count_d    = count_q;
        tick_d     = 1'b0;
        if (bus.start) begin
            state_next = ST_RUN;
            count_d    = '0;
        end else if (bus.stop) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_RUN: begin
                    count_d = count_q + 1'b1;
                    tick_d  = (count_q == CNT_MAX);
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    assign bus.count    = count_q;
    assign bus.running  = (state == ST_RUN);
    assign bus.tick     = tick_q;
    assign bus.clk_div2 = count_q[0];
    assign bus.clk_out  = count_q[CNT_W-1];

`ifdef FREQDIV_DIV3_EN
    logic       advance;
    logic [1:0] div3_cnt;
    logic       div3_neg;

    assign advance = (state == ST_RUN) && !bus.start && !bus.stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div3_cnt <= 2'd0;
        end else if (bus.start) begin
            div3_cnt <= 2'd0;
        end else if (advance) begin
            div3_cnt <= (div3_cnt == 2'd2) ? 2'd0 : div3_cnt + 2'd1;
        end
    end

    // Half-cycle delayed copy stretches the one-of-three high phase to 1.5 cycles
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div3_neg <= 1'b0;
        end else if (bus.start) begin
            div3_neg <= 1'b0;
        end else if (state == ST_RUN) begin
            div3_neg <= div3_cnt[0];
        end
    end

    assign bus.clk_div3 = (state == ST_RUN) && (div3_cnt[0] || div3_neg);
`else
    assign bus.clk_div3 = 1'b0;
`endif
endmodule

// File: tb/tb_frequency_divider.sv
// tb/tb_frequency_divider.sv - directed plus random bench for frequency_divider
module tb_frequency_divider;
    localparam int CNT_W = 2;
    localparam int M     = 1 << CNT_W;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    int   m_count;
    bit   m_run;
    bit   m_tick;

    frequency_divider_if #(.CNT_W(CNT_W)) bus ();

    frequency_divider #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(bus.count), 32'(m_count));
        chk({tag, ".running"}, 32'(bus.running), 32'(m_run));
        chk({tag, ".tick"}, 32'(bus.tick), 32'(m_tick));
        chk({tag, ".clk_div2"}, 32'(bus.clk_div2), 32'(m_count % 2));
        chk({tag, ".clk_out"}, 32'(bus.clk_out), 32'(m_count >= M / 2));
`ifndef FREQDIV_DIV3_EN
        chk({tag, ".clk_div3"}, 32'(bus.clk_div3), 32'd0);
`endif
    endtask

    // One rising edge: apply commands, advance the reference, check after the edge
    task automatic cycle(input bit s, input bit p, input string tag);
        bus.start = s;
        bus.stop  = p;
        @(posedge clk);
        if (s) begin
            m_count = 0;
            m_run   = 1'b1;
            m_tick  = 1'b0;
        end else if (p) begin
            m_run  = 1'b0;
            m_tick = 1'b0;
        end else if (m_run) begin
            m_tick  = (m_count == M - 1);
            m_count = (m_count + 1) % M;
        end else begin
            m_tick = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        int rise_t[$];
        int fall_t[$];
        logic prev;
        total     = 0;
        bad       = 0;
        m_count   = 0;
        m_run     = 1'b0;
        m_tick    = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.stop  = 1'b0;

        // reset held with start high
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, "post_reset0");
        cycle(1'b0, 1'b0, "post_reset1");

        // start pulse then count 1,2,3, wrap with tick
        cycle(1'b1, 1'b0, "start");
        chk("start_count0", 32'(bus.count), 32'd0);
        cycle(1'b0, 1'b0, "cnt1");
        chk("first_inc", 32'(bus.count), 32'd1);
        cycle(1'b0, 1'b0, "cnt2");
        cycle(1'b0, 1'b0, "cnt3");
        cycle(1'b0, 1'b0, "wrap");
        chk("wrap_tick", 32'(bus.tick), 32'd1);
        cycle(1'b0, 1'b0, "after_wrap");
        chk("tick_one_cycle", 32'(bus.tick), 32'd0);

        // restart mid-count
        cycle(1'b1, 1'b0, "restart");
        cycle(1'b0, 1'b0, "restart_inc");
        cycle(1'b0, 1'b0, "to2");

        // stop holds count, then start and stop together
        cycle(1'b0, 1'b1, "stop0");
        cycle(1'b0, 1'b1, "stop1");
        cycle(1'b0, 1'b1, "stop2");
        chk("stop_hold", 32'(bus.count), 32'd2);
        cycle(1'b0, 1'b0, "idle0");
        cycle(1'b0, 1'b0, "idle1");
        cycle(1'b1, 1'b1, "start_wins");
        chk("start_wins_run", 32'(bus.running), 32'd1);
        cycle(1'b1, 1'b0, "hold_start0");
        cycle(1'b1, 1'b0, "hold_start1");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, "clk_out_run");

        // asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_count", 32'(bus.count), 32'd0);
        chk("async_running", 32'(bus.running), 32'd0);
        m_count = 0;
        m_run   = 1'b0;
        m_tick  = 1'b0;
        #2;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, "after_async0");
        cycle(1'b0, 1'b0, "after_async1");

        // random commands against the reference
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom % 10) == 0, ($urandom % 8) == 0, "rand");
        end

        // clk_div3 waveform measurement
        cycle(1'b1, 1'b0, "div3_start");
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        prev = bus.clk_div3;
        for (int t = 0; t < 120; t++) begin
            #1;
            if (bus.clk_div3 === 1'b1 && prev !== 1'b1) rise_t.push_back(t);
            if (bus.clk_div3 !== 1'b1 && prev === 1'b1) fall_t.push_back(t);
            prev = bus.clk_div3;
        end
`ifdef FREQDIV_DIV3_EN
        chk("div3_edges", 32'(rise_t.size() >= 2 && fall_t.size() >= 1), 32'd1);
        if (rise_t.size() >= 2 && fall_t.size() >= 1) begin
            chk("div3_period", 32'(rise_t[1] - rise_t[0]), 32'd30);
            chk("div3_high", 32'(fall_t[0] - rise_t[0]), 32'd15);
        end
`else
        chk("div3_static", 32'(rise_t.size() + fall_t.size()), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
